// File: rtl/simd_issue_arb_pkg.sv
// Shared types and constants for the SIMD issue arbiter and the SIMD unit wrapper.
// Latency: n/a (types only).
// Backpressure: n/a.
package simd_issue_arb_pkg;

  localparam int SIMD_LAT   = 2;
  localparam int SIMD_DEPTH = 4;
  localparam int SIMD_TAG_W = 6;

  typedef enum logic [12:0] {
    SIMD_NOP  = 13'h0000,
    SIMD_PADD = 13'h0001,
    SIMD_PSUB = 13'h0002,
    SIMD_PAND = 13'h0004,
    SIMD_PXOR = 13'h0008
  } simd_op_e;

  typedef struct packed {
    logic [12:0]           op;
    logic [67:0]           a;
    logic [67:0]           b;
    logic [SIMD_TAG_W-1:0] tag;
  } simd_req_t;

  typedef struct packed {
    logic [67:0]           data;
    logic [SIMD_TAG_W-1:0] tag;
    logic                  src;
  } simd_res_t;

endpackage

// File: rtl/simd_issue_arb_if.sv
// Bundle of issue-port, SIMD-unit and result-port signals around the arbiter.
// Latency: n/a (wiring only).
// Backpressure: req_ready per port, res_ready from the consumer.
interface simd_issue_arb_if;
  import simd_issue_arb_pkg::*;

  logic [1:0]                 req_valid;
  logic [1:0]                 req_ready;
  logic [1:0][12:0]           req_op;
  logic [1:0][67:0]           req_A;
  logic [1:0][67:0]           req_B;
  logic [1:0][SIMD_TAG_W-1:0] req_tag;

  logic                       simd_en;
  logic [12:0]                simd_operation;
  logic [67:0]                simd_A;
  logic [67:0]                simd_B;
  logic [67:0]                simd_res;

  logic                       res_valid;
  logic                       res_ready;
  logic [67:0]                res_data;
  logic [SIMD_TAG_W-1:0]      res_tag;
  logic                       res_src;

  logic                       flush;
  logic                       busy;

  // Arbiter side.
  modport slave (
    input  req_valid, req_op, req_A, req_B, req_tag, simd_res, res_ready, flush,
    output req_ready, simd_en, simd_operation, simd_A, simd_B,
           res_valid, res_data, res_tag, res_src, busy
  );

  // Issue queues / SIMD unit / consumer side.
  modport master (
    output req_valid, req_op, req_A, req_B, req_tag, simd_res, res_ready, flush,
    input  req_ready, simd_en, simd_operation, simd_A, simd_B,
           res_valid, res_data, res_tag, res_src, busy
  );

endinterface

// File: rtl/simd_issue_arb_res_fifo.sv
// Circular result buffer holding SIMD results until the consumer accepts them.
// Latency: push visible at the head one cycle later; head is combinational.
// Backpressure: none internally; the arbiter's credits keep pushes from overflowing.
module simd_res_fifo
  import simd_issue_arb_pkg::*;
#(
  parameter  int DEPTH = SIMD_DEPTH,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  simd_res_t     push_dat,
  input  logic          pop,
  input  logic          flush,
  output logic          vld,
  output simd_res_t     head,
  output logic [CW-1:0] count
);

  simd_res_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Flush wins over both push and pop in the same cycle.
  assign do_push = push & ~flush;
  assign do_pop  = pop & (count != '0) & ~flush;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Pointer and occupancy bookkeeping, wrapping at DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop)  rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Payload storage; no reset needed because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  assign vld  = (count != '0);
  assign head = mem[rd_ptr];

  no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(do_push && !do_pop && count == CW'(DEPTH)));

endmodule

// File: rtl/simd_issue_arb.sv
// Round-robin arbiter of two issue ports onto one fixed-latency SIMD unit, with a result buffer.
// Latency: grant -> simd_en 1 cycle; grant -> res_valid LAT+2 cycles.
// Backpressure: credits (buffer slots) gate grants; res_ready stalls only the buffer head.
module simd_issue_arb
  import simd_issue_arb_pkg::*;
#(
  parameter int LAT   = SIMD_LAT,
  parameter int DEPTH = SIMD_DEPTH,
  parameter int TAG_W = SIMD_TAG_W
) (
  input logic             clk,
  input logic             rst,
  simd_issue_arb_if.slave bus
);

  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic             vld;
    logic             src;
    logic [TAG_W-1:0] tag;
  } stage_t;

  logic [CW-1:0] credits;
  logic [CW-1:0] inflight_n;
  logic [CW-1:0] fifo_cnt;
  logic          rr_ptr;
  logic          win;
  logic          issue;
  logic          pop;
  logic          head_vld;
  stage_t [LAT:0] pipe;
  simd_res_t     push_dat;
  simd_res_t     head;

  // Pick the winner from registered rr state; grant only with a free slot and no flush.
  always_comb begin
    win           = bus.req_valid[1] & (~bus.req_valid[0] | rr_ptr);
    issue         = rst & ~bus.flush & (credits != '0) & (|bus.req_valid);
    bus.req_ready = issue ? (win ? 2'b10 : 2'b01) : 2'b00;
  end

  assign pop = head_vld & bus.res_ready & ~bus.flush;

  // One slot per issued op, returned when its result leaves the buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           credits <= CW'(DEPTH);
    else if (bus.flush) credits <= CW'(DEPTH);
    else                credits <= credits - CW'(issue) + CW'(pop);
  end

  // Next preference goes to the port that did not just win; held otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       rr_ptr <= 1'b0;
    else if (issue) rr_ptr <= ~win;
  end

  // Issue register toward the SIMD unit; payload holds when nothing is granted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.simd_en        <= 1'b0;
      bus.simd_operation <= '0;
      bus.simd_A         <= '0;
      bus.simd_B         <= '0;
    end else begin
      bus.simd_en <= issue;
      if (issue) begin
        bus.simd_operation <= bus.req_op[win];
        bus.simd_A         <= bus.req_A[win];
        bus.simd_B         <= bus.req_B[win];
      end
    end
  end

  // Source/tag shadow of every op in the unit; stage LAT lines up with simd_res.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe <= '0;
    end else if (bus.flush) begin
      pipe <= '0;
    end else begin
      pipe[0] <= '{vld: issue, src: win, tag: bus.req_tag[win]};
      for (int k = 1; k <= LAT; k++) pipe[k] <= pipe[k-1];
    end
  end

  // Number of ops still inside the unit.
  always_comb begin
    inflight_n = '0;
    for (int k = 0; k <= LAT; k++) inflight_n = inflight_n + CW'(pipe[k].vld);
  end

  assign push_dat = '{data: bus.simd_res, tag: pipe[LAT].tag, src: pipe[LAT].src};

  simd_res_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (pipe[LAT].vld),
    .push_dat (push_dat),
    .pop      (pop),
    .flush    (bus.flush),
    .vld      (head_vld),
    .head     (head),
    .count    (fifo_cnt)
  );

  assign bus.res_valid = head_vld;
  assign bus.res_data  = head.data;
  assign bus.res_tag   = head.tag;
  assign bus.res_src   = head.src;
  assign bus.busy      = (inflight_n != '0) | (fifo_cnt != '0);

  credit_inv: assert property (@(posedge clk) disable iff (!rst)
    credits + inflight_n + fifo_cnt == CW'(DEPTH));

endmodule

// File: tb/tb_simd_issue_arb.sv
module tb_simd_issue_arb;
  import simd_issue_arb_pkg::*;

  localparam int LAT   = SIMD_LAT;
  localparam int DEPTH = SIMD_DEPTH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   n_issued = 0;

  simd_issue_arb_if bus();

  simd_issue_arb #(.LAT(LAT), .DEPTH(DEPTH), .TAG_W(SIMD_TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // What the SIMD unit computes for an op.
  function automatic logic [67:0] unit_fn(input logic [12:0] op, input logic [67:0] a,
                                          input logic [67:0] b);
    case (op)
      SIMD_PADD: return a + b;
      SIMD_PSUB: return a - b;
      SIMD_PAND: return a & b;
      default:   return a ^ b;
    endcase
  endfunction

  function automatic logic [12:0] pick_op();
    case ($urandom_range(0, 3))
      0:       return SIMD_PADD;
      1:       return SIMD_PSUB;
      2:       return SIMD_PAND;
      default: return SIMD_PXOR;
    endcase
  endfunction

  // SIMD unit stand-in: result appears LAT cycles after simd_en, junk otherwise.
  logic [67:0] hist [LAT+1];
  always @(negedge clk) begin
    for (int k = LAT; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = bus.simd_en ? unit_fn(bus.simd_operation, bus.simd_A, bus.simd_B)
                          : {4'($urandom), $urandom, $urandom};
    bus.simd_res = hist[LAT];
  end

  // Reference model: outstanding ops, round-robin preference, ordered expected results.
  typedef struct {
    logic [67:0]           data;
    logic [SIMD_TAG_W-1:0] tag;
    logic                  src;
    int                    due;
  } exp_t;

  exp_t       q[$];
  exp_t       e;
  int         outstanding = 0;
  logic       pref = 1'b0;
  logic       w;
  logic       exp_vld;
  logic [1:0] exp_rdy;

  always @(negedge clk) begin
    if (!rst) begin
      q.delete();
      outstanding = 0;
      pref = 1'b0;
    end else begin
      exp_rdy = 2'b00;
      w = 1'b0;
      if (!bus.flush && outstanding < DEPTH && bus.req_valid != 2'b00) begin
        w = (bus.req_valid == 2'b11) ? pref : bus.req_valid[1];
        exp_rdy[w] = 1'b1;
      end
      check("req_ready", 128'(bus.req_ready), 128'(exp_rdy));
      check("busy", 128'(bus.busy), 128'(outstanding != 0));
      exp_vld = 1'b0;
      if (q.size() != 0) exp_vld = (q[0].due <= cyc);
      check("res_valid", 128'(bus.res_valid), 128'(exp_vld));
      if (bus.flush) begin
        q.delete();
        outstanding = 0;
      end else begin
        if (exp_vld && bus.res_ready) begin
          e = q.pop_front();
          check("res_data", 128'(bus.res_data), 128'(e.data));
          check("res_tag", 128'(bus.res_tag), 128'(e.tag));
          check("res_src", 128'(bus.res_src), 128'(e.src));
          outstanding--;
        end
        if (exp_rdy != 2'b00) begin
          e.data = unit_fn(bus.req_op[w], bus.req_A[w], bus.req_B[w]);
          e.tag  = bus.req_tag[w];
          e.src  = w;
          e.due  = cyc + LAT + 2;
          q.push_back(e);
          outstanding++;
          pref = ~w;
          n_issued++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_port(input int p);
    bus.req_op[p]  = pick_op();
    bus.req_A[p]   = {4'($urandom), $urandom, $urandom};
    bus.req_B[p]   = {4'($urandom), $urandom, $urandom};
    bus.req_tag[p] = SIMD_TAG_W'($urandom);
  endtask

  task automatic drain(input logic toggle);
    int g = 0;
    bus.req_valid = 2'b00;
    while (bus.busy && g < 100) begin
      bus.res_ready = toggle ? ~bus.res_ready : 1'b1;
      step();
      g++;
    end
    check("drain_idle", 128'(bus.busy), 128'(0));
  endtask

  initial begin
    int base;
    int g;
    bus.req_valid = 2'b01;
    bus.flush     = 1'b0;
    bus.res_ready = 1'b0;
    rand_port(0);
    rand_port(1);
    #1 rst = 1'b0;
    step();
    step();
    // Reset state, with a port requesting to show grants are held off.
    check("rst_simd_en", 128'(bus.simd_en), 128'(0));
    check("rst_res_valid", 128'(bus.res_valid), 128'(0));
    check("rst_req_ready", 128'(bus.req_ready), 128'(0));
    check("rst_busy", 128'(bus.busy), 128'(0));
    check("rst_simd_op", 128'(bus.simd_operation), 128'(0));
    check("rst_simd_A", 128'(bus.simd_A), 128'(0));
    check("rst_simd_B", 128'(bus.simd_B), 128'(0));
    bus.req_valid = 2'b00;
    rst = 1'b1;
    step();

    // Single op on port 0.
    bus.req_op[0]  = SIMD_PADD;
    bus.req_A[0]   = 68'd1;
    bus.req_B[0]   = 68'd2;
    bus.req_tag[0] = 6'd5;
    bus.req_valid  = 2'b01;
    #1 check("single_grant", 128'(bus.req_ready), 128'(2'b01));
    step();
    bus.req_valid = 2'b00;
    #1;
    check("single_simd_en", 128'(bus.simd_en), 128'(1));
    check("single_simd_op", 128'(bus.simd_operation), 128'(SIMD_PADD));
    check("single_simd_A", 128'(bus.simd_A), 128'(1));
    check("single_simd_B", 128'(bus.simd_B), 128'(2));
    repeat (LAT) step();
    #1 check("single_not_yet", 128'(bus.res_valid), 128'(0));
    step();
    #1;
    check("single_res_valid", 128'(bus.res_valid), 128'(1));
    check("single_res_data", 128'(bus.res_data), 128'(3));
    check("single_res_tag", 128'(bus.res_tag), 128'(5));
    check("single_res_src", 128'(bus.res_src), 128'(0));
    drain(1'b0);

    // Contention: both ports every cycle, consumer always ready.
    bus.res_ready = 1'b1;
    repeat (24) begin
      rand_port(0);
      rand_port(1);
      bus.req_valid = 2'b11;
      step();
    end
    drain(1'b0);

    // Back-pressure: only DEPTH grants until a pop frees a slot.
    base = n_issued;
    bus.res_ready = 1'b0;
    repeat (10) begin
      rand_port(0);
      bus.req_valid = 2'b01;
      step();
    end
    check("bp_grants", 128'(n_issued - base), 128'(DEPTH));
    bus.res_ready = 1'b1;
    rand_port(0);
    step();
    bus.res_ready = 1'b0;
    repeat (4) begin
      rand_port(0);
      step();
    end
    check("bp_one_more", 128'(n_issued - base), 128'(DEPTH + 1));
    drain(1'b0);

    // Ten ops with res_ready toggling, random port mix.
    base = n_issued;
    g = 0;
    while (n_issued - base < 10 && g < 300) begin
      rand_port(0);
      rand_port(1);
      bus.req_valid = 2'($urandom_range(1, 3));
      bus.res_ready = ~bus.res_ready;
      step();
      g++;
    end
    bus.req_valid = 2'b00;
    check("toggle_ops", 128'(n_issued - base), 128'(10));
    drain(1'b1);

    // Flush with two ops buffered and two in flight.
    bus.res_ready = 1'b0;
    repeat (4) begin
      rand_port(0);
      bus.req_valid = 2'b01;
      step();
    end
    bus.req_valid = 2'b00;
    step();
    bus.flush = 1'b1;
    #1;
    check("pre_flush_busy", 128'(bus.busy), 128'(1));
    check("pre_flush_res_valid", 128'(bus.res_valid), 128'(1));
    step();
    bus.flush = 1'b0;
    #1;
    check("flush_res_valid", 128'(bus.res_valid), 128'(0));
    check("flush_busy", 128'(bus.busy), 128'(0));
    repeat (LAT + 2) step();
    rand_port(0);
    rand_port(1);
    bus.req_valid = 2'b11;
    #1 check("flush_rr_kept", 128'(bus.req_ready), 128'(2'b10));
    step();
    drain(1'b0);

    // Asynchronous reset between clock edges while streaming.
    bus.res_ready = 1'b1;
    repeat (6) begin
      rand_port(0);
      rand_port(1);
      bus.req_valid = 2'b11;
      step();
    end
    #2 rst = 1'b0;
    #1;
    check("arst_simd_en", 128'(bus.simd_en), 128'(0));
    check("arst_res_valid", 128'(bus.res_valid), 128'(0));
    check("arst_req_ready", 128'(bus.req_ready), 128'(0));
    check("arst_busy", 128'(bus.busy), 128'(0));
    step();
    step();
    rand_port(0);
    rand_port(1);
    rst = 1'b1;
    #1 check("arst_first_grant", 128'(bus.req_ready), 128'(2'b01));
    step();
    drain(1'b0);

    check("scoreboard_empty", 128'(q.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
